// File: rtl/maze_pkg.sv
// maze_pkg
// Shared types and helpers for the maze game-logic block.
//   maze_state_t : controller FSM states
//   dir_t        : decoded movement direction
//   tile_addr()  : maze ROM address of a tile, bcol*ROW_STRIDE + brow, 11 bits
package maze_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      CHECK,
      WIN
   } maze_state_t;

   typedef enum logic [2:0] {
      NONE,
      UP,
      DOWN,
      LEFT,
      RIGHT
   } dir_t;

   // Pixel-to-tile shift (16-pixel tiles) and the ROM row stride per column.
   localparam int TILE_SHIFT = 4;
   localparam int ROW_STRIDE = 32;

   // Zero-extend before the multiply so the column term is not truncated
   // to the 6-bit operand width.
   function automatic logic [10:0] tile_addr(input logic [5:0] bcol,
                                             input logic [5:0] brow);
      return (11'(bcol) * 11'(ROW_STRIDE)) + 11'(brow);
   endfunction

endpackage

// File: rtl/maze_dir_sel.sv
// maze_dir_sel
// Combinational direction picker and target-tile calculator.
//   i_up/i_down/i_left/i_right : button levels (priority up > down > left > right)
//   i_bcol/i_brow              : current player tile
//   o_dir                      : selected direction (dir_t encoding), NONE if no button
//   o_tgt_bcol/o_tgt_brow      : neighbouring tile in the selected direction
//   o_in_bounds                : target lies inside the grid (0 when o_dir is NONE)
import maze_pkg::*;

module maze_dir_sel #(
   parameter int GRID_COLS = 40,
   parameter int GRID_ROWS = 30
) (
   input  logic       i_up,
   input  logic       i_down,
   input  logic       i_left,
   input  logic       i_right,
   input  logic [5:0] i_bcol,
   input  logic [5:0] i_brow,
   output logic [2:0] o_dir,
   output logic [5:0] o_tgt_bcol,
   output logic [5:0] o_tgt_brow,
   output logic       o_in_bounds
);

   dir_t       w_dir;
   // One extra bit so the +1 check cannot wrap.
   logic [6:0] w_col_inc;
   logic [6:0] w_row_inc;

   assign w_col_inc = {1'b0, i_bcol} + 7'd1;
   assign w_row_inc = {1'b0, i_brow} + 7'd1;

   always_comb begin
      w_dir       = NONE;
      o_tgt_bcol  = i_bcol;
      o_tgt_brow  = i_brow;
      o_in_bounds = 1'b0;
      if (i_up) begin
         w_dir       = UP;
         o_tgt_brow  = i_brow - 6'd1;
         o_in_bounds = (i_brow != 6'd0);
      end else if (i_down) begin
         w_dir       = DOWN;
         o_tgt_brow  = w_row_inc[5:0];
         o_in_bounds = (w_row_inc < 7'(GRID_ROWS));
      end else if (i_left) begin
         w_dir       = LEFT;
         o_tgt_bcol  = i_bcol - 6'd1;
         o_in_bounds = (i_bcol != 6'd0);
      end else if (i_right) begin
         w_dir       = RIGHT;
         o_tgt_bcol  = w_col_inc[5:0];
         o_in_bounds = (w_col_inc < 7'(GRID_COLS));
      end
   end

   assign o_dir = w_dir;

endmodule

// File: rtl/maze_ctrl.sv
// maze_ctrl
// Player/exit position owner for the maze game. On a movement tick it picks
// a direction, range-checks the neighbouring tile, reads it from the maze ROM
// (port B) and commits the move only if the tile is free.
//   clk, rst                 : clock, asynchronous active-high reset
//   i_tick                   : one-cycle movement strobe
//   i_up/i_down/i_left/i_right : debounced button levels
//   o_rom_en/o_rom_addr      : ROM read request (addr = bcol*32 + brow)
//   i_rom_data               : ROM data, valid the cycle after o_rom_en
//   o_player_bcol/brow       : player tile
//   o_exit_bcol/brow         : exit tile (constant)
//   o_moves                  : committed moves, saturating
//   o_win                    : sticky, player reached the exit
import maze_pkg::*;

module maze_ctrl #(
   parameter int          GRID_COLS  = 40,
   parameter int          GRID_ROWS  = 30,
   parameter logic [11:0] FREE_RGB   = 12'hFFF,
   parameter int          START_BCOL = 1,
   parameter int          START_BROW = 1,
   parameter int          EXIT_BCOL  = 38,
   parameter int          EXIT_BROW  = 28
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_tick,
   input  logic        i_up,
   input  logic        i_down,
   input  logic        i_left,
   input  logic        i_right,
   output logic        o_rom_en,
   output logic [10:0] o_rom_addr,
   input  logic [15:0] i_rom_data,
   output logic [5:0]  o_player_bcol,
   output logic [5:0]  o_player_brow,
   output logic [5:0]  o_exit_bcol,
   output logic [5:0]  o_exit_brow,
   output logic [15:0] o_moves,
   output logic        o_win
);

   maze_state_t r_state, w_state_next;
   logic [5:0]  r_player_bcol, w_player_bcol_next;
   logic [5:0]  r_player_brow, w_player_brow_next;
   logic [5:0]  r_tgt_bcol, w_tgt_bcol_next;
   logic [5:0]  r_tgt_brow, w_tgt_brow_next;
   logic [15:0] r_moves, w_moves_next;
   logic        r_win, w_win_next;
   logic        r_rom_en, w_rom_en_next;
   logic [10:0] r_rom_addr, w_rom_addr_next;

   logic [2:0]  w_dir;
   logic [5:0]  w_tgt_bcol;
   logic [5:0]  w_tgt_brow;
   logic        w_in_bounds;
   logic        w_tile_free;
   logic        w_unused_rom;

   maze_dir_sel #(
      .GRID_COLS (GRID_COLS),
      .GRID_ROWS (GRID_ROWS)
   ) u_dir_sel (
      .i_up        (i_up),
      .i_down      (i_down),
      .i_left      (i_left),
      .i_right     (i_right),
      .i_bcol      (r_player_bcol),
      .i_brow      (r_player_brow),
      .o_dir       (w_dir),
      .o_tgt_bcol  (w_tgt_bcol),
      .o_tgt_brow  (w_tgt_brow),
      .o_in_bounds (w_in_bounds)
   );

   // Only the 12-bit colour field decides walkability; upper bits are ignored.
   assign w_tile_free  = (i_rom_data[11:0] == FREE_RGB);
   assign w_unused_rom = ^i_rom_data[15:12];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_player_bcol <= 6'(START_BCOL);
         r_player_brow <= 6'(START_BROW);
         r_tgt_bcol    <= 6'(START_BCOL);
         r_tgt_brow    <= 6'(START_BROW);
         r_moves       <= 16'd0;
         r_win         <= 1'b0;
         r_rom_en      <= 1'b0;
         r_rom_addr    <= 11'd0;
      end else begin
         r_state       <= w_state_next;
         r_player_bcol <= w_player_bcol_next;
         r_player_brow <= w_player_brow_next;
         r_tgt_bcol    <= w_tgt_bcol_next;
         r_tgt_brow    <= w_tgt_brow_next;
         r_moves       <= w_moves_next;
         r_win         <= w_win_next;
         r_rom_en      <= w_rom_en_next;
         r_rom_addr    <= w_rom_addr_next;
      end
   end

   // o_rom_en is registered, so it is raised on the IDLE->REQ transition and
   // is therefore high for exactly the REQ cycle.
   always_comb begin
      w_state_next       = r_state;
      w_player_bcol_next = r_player_bcol;
      w_player_brow_next = r_player_brow;
      w_tgt_bcol_next    = r_tgt_bcol;
      w_tgt_brow_next    = r_tgt_brow;
      w_moves_next       = r_moves;
      w_win_next         = r_win;
      w_rom_en_next      = 1'b0;
      w_rom_addr_next    = r_rom_addr;
      case (r_state)
         IDLE: begin
            if (i_tick && (w_dir != NONE) && w_in_bounds) begin
               w_tgt_bcol_next = w_tgt_bcol;
               w_tgt_brow_next = w_tgt_brow;
               w_rom_en_next   = 1'b1;
               w_rom_addr_next = tile_addr(w_tgt_bcol, w_tgt_brow);
               w_state_next    = REQ;
            end
         end
         REQ: begin
            w_state_next = CHECK;
         end
         CHECK: begin
            w_state_next = IDLE;
            if (w_tile_free) begin
               w_player_bcol_next = r_tgt_bcol;
               w_player_brow_next = r_tgt_brow;
               if (r_moves != 16'hFFFF) begin
                  w_moves_next = r_moves + 16'd1;
               end
               if ((r_tgt_bcol == 6'(EXIT_BCOL)) && (r_tgt_brow == 6'(EXIT_BROW))) begin
                  w_win_next   = 1'b1;
                  w_state_next = WIN;
               end
            end
         end
         WIN: begin
            w_state_next = WIN;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign o_rom_en      = r_rom_en;
   assign o_rom_addr    = r_rom_addr;
   assign o_player_bcol = r_player_bcol;
   assign o_player_brow = r_player_brow;
   assign o_exit_bcol   = 6'(EXIT_BCOL);
   assign o_exit_brow   = 6'(EXIT_BROW);
   assign o_moves       = r_moves;
   assign o_win         = r_win;

endmodule

// File: tb/tb_maze_ctrl.sv
// tb_maze_ctrl
// Self-checking bench for maze_ctrl: a synchronous-read ROM model feeds the
// DUT, and a tile-level reference model (player position, move count, win)
// predicts the result of every tick.
module tb_maze_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_tick = 1'b0;
   logic        i_up = 1'b0;
   logic        i_down = 1'b0;
   logic        i_left = 1'b0;
   logic        i_right = 1'b0;
   logic        o_rom_en;
   logic [10:0] o_rom_addr;
   logic [15:0] i_rom_data;
   logic [5:0]  o_player_bcol;
   logic [5:0]  o_player_brow;
   logic [5:0]  o_exit_bcol;
   logic [5:0]  o_exit_brow;
   logic [15:0] o_moves;
   logic        o_win;

   logic [15:0] mem [0:2047];
   logic [15:0] rom_q = 16'd0;

   int n_vec = 0;
   int n_err = 0;
   int n_txn = 0;

   // Reference model state
   int m_col, m_row, m_moves;
   bit m_win;

   maze_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .i_tick        (i_tick),
      .i_up          (i_up),
      .i_down        (i_down),
      .i_left        (i_left),
      .i_right       (i_right),
      .o_rom_en      (o_rom_en),
      .o_rom_addr    (o_rom_addr),
      .i_rom_data    (i_rom_data),
      .o_player_bcol (o_player_bcol),
      .o_player_brow (o_player_brow),
      .o_exit_bcol   (o_exit_bcol),
      .o_exit_brow   (o_exit_brow),
      .o_moves       (o_moves),
      .o_win         (o_win)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (o_rom_en) rom_q <= mem[o_rom_addr];
   end
   assign i_rom_data = rom_q;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, got running, need finished");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_col = 1; m_row = 1; m_moves = 0; m_win = 0;
   endtask

   task automatic fill_free();
      for (int a = 0; a < 2048; a++) mem[a] = 16'h0FFF;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // One tick transaction: predict from the model, apply, then check reads,
   // address, position, count and win flag once the move has settled.
   task automatic apply_tick(input logic up, input logic dn, input logic lf,
                             input logic rt, input bit drop);
      int tc, tr, exp_reads, exp_addr, reads, addr;
      bit legal, drop_eff, free;
      tc = m_col; tr = m_row;
      if (up) tr = tr - 1;
      else if (dn) tr = tr + 1;
      else if (lf) tc = tc - 1;
      else if (rt) tc = tc + 1;
      legal = !m_win && (up || dn || lf || rt) &&
              tc >= 0 && tc < 40 && tr >= 0 && tr < 30;
      exp_reads = legal ? 1 : 0;
      exp_addr  = tc * 32 + tr;
      // Extra ticks only land in REQ/CHECK when a move is actually in flight.
      drop_eff  = drop && legal;

      @(negedge clk);
      i_up = up; i_down = dn; i_left = lf; i_right = rt; i_tick = 1'b1;
      reads = 0; addr = -1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         i_tick = drop_eff && (c < 2);
         if (o_rom_en === 1'b1) begin
            reads++;
            addr = int'(o_rom_addr);
         end
      end
      i_tick = 1'b0; i_up = 1'b0; i_down = 1'b0; i_left = 1'b0; i_right = 1'b0;

      if (legal) begin
         free = (mem[exp_addr][11:0] == 12'hFFF);
         if (free) begin
            m_col = tc; m_row = tr;
            if (m_moves < 65535) m_moves++;
            if (tc == 38 && tr == 28) m_win = 1;
         end
      end

      n_txn++;
      $display("txn %0d: btn(udlr)=%b%b%b%b drop=%0d reads=%0d addr=%0d pos=(%0d,%0d) moves=%0d win=%0d",
               n_txn, up, dn, lf, rt, drop_eff, reads, addr,
               o_player_bcol, o_player_brow, o_moves, o_win);

      n_vec++;
      if (reads !== exp_reads) begin
         n_err++;
         $display("FAIL rom_reads txn %0d: got %0d, need %0d", n_txn, reads, exp_reads);
      end
      if (exp_reads == 1) begin
         n_vec++;
         if (addr !== exp_addr) begin
            n_err++;
            $display("FAIL rom_addr txn %0d: got %0d, need %0d", n_txn, addr, exp_addr);
         end
      end
      n_vec++;
      if (int'(o_player_bcol) !== m_col || int'(o_player_brow) !== m_row) begin
         n_err++;
         $display("FAIL player txn %0d: got (%0d,%0d), need (%0d,%0d)",
                  n_txn, o_player_bcol, o_player_brow, m_col, m_row);
      end
      n_vec++;
      if (int'(o_moves) !== m_moves) begin
         n_err++;
         $display("FAIL moves txn %0d: got %0d, need %0d", n_txn, o_moves, m_moves);
      end
      n_vec++;
      if (o_win !== m_win) begin
         n_err++;
         $display("FAIL win txn %0d: got %0b, need %0b", n_txn, o_win, m_win);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      n_vec++;
      if (o_player_bcol !== 6'd1 || o_player_brow !== 6'd1 || o_moves !== 16'd0 ||
          o_win !== 1'b0 || o_rom_en !== 1'b0) begin
         n_err++;
         $display("FAIL %s: got pos=(%0d,%0d) moves=%0d win=%b en=%b, need pos=(1,1) moves=0 win=0 en=0",
                  name, o_player_bcol, o_player_brow, o_moves, o_win, o_rom_en);
      end
   endtask

   task automatic test_reset();
      fill_free();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset_state");
      n_vec++;
      if (o_rom_addr !== 11'd0) begin
         n_err++;
         $display("FAIL reset_addr: got %0d, need 0", o_rom_addr);
      end
      n_vec++;
      if (o_exit_bcol !== 6'd38 || o_exit_brow !== 6'd28) begin
         n_err++;
         $display("FAIL exit_pos: got (%0d,%0d), need (38,28)", o_exit_bcol, o_exit_brow);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_free_move();
      fill_free();
      do_reset();
      apply_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);   // expects read at 65, (2,1)
      // A tick with no buttons does nothing.
      apply_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_wall_block();
      fill_free();
      mem[34] = 16'h0000;
      do_reset();
      apply_tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);   // read at 34, blocked
      // Free colour with non-zero upper bits is still walkable.
      mem[34] = 16'hA000 | 16'h0FFF;
      apply_tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      fill_free();
   endtask

   task automatic test_boundary();
      fill_free();
      do_reset();
      apply_tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);   // (0,1)
      apply_tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // (0,0)
      apply_tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);   // rejected, no read
      apply_tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // rejected, no read
      apply_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);   // still accepts moves afterwards
   endtask

   task automatic test_priority_drop();
      fill_free();
      do_reset();
      apply_tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);   // (1,2)
      apply_tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);   // up wins, addr 33, extra ticks dropped
      apply_tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);   // down over left/right
   endtask

   task automatic test_mid_reset();
      fill_free();
      do_reset();
      apply_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);   // (2,1), moves 1
      @(negedge clk);
      i_right = 1'b1; i_tick = 1'b1;
      @(negedge clk);                              // REQ
      i_tick = 1'b0;
      @(negedge clk);                              // CHECK
      rst = 1'b1;
      #1;
      check_idle_outputs("mid_reset_async");
      @(negedge clk);
      rst = 1'b0; i_right = 1'b0;
      model_reset();
      @(negedge clk);
      check_idle_outputs("mid_reset_release");
      apply_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);   // normal move after abort
   endtask

   task automatic test_random();
      logic [3:0] b;
      fill_free();
      for (int a = 0; a < 2048; a++) begin
         if ($urandom_range(0, 3) == 0) mem[a] = 16'(($urandom_range(0, 15) << 12) | $urandom_range(0, 12'hFFE));
         else mem[a] = 16'(($urandom_range(0, 15) << 12) | 12'hFFF);
      end
      do_reset();
      for (int k = 0; k < 120; k++) begin
         b = 4'($urandom_range(0, 15));
         apply_tick(b[3], b[2], b[1], b[0], bit'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_win();
      fill_free();
      do_reset();
      for (int k = 0; k < 37; k++) apply_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 27; k++) apply_tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      // Terminal: further ticks cause no reads and no movement.
      apply_tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      apply_tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (o_win !== 1'b1 || o_moves !== 16'd64) begin
         n_err++;
         $display("FAIL win_final: got win=%b moves=%0d, need win=1 moves=64", o_win, o_moves);
      end
      do_reset();
      check_idle_outputs("win_then_reset");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_free_move();
      test_wall_block();
      test_boundary();
      test_priority_drop();
      test_mid_reset();
      test_random();
      test_win();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/maze_ctrl.md
Name: maze_ctrl

Overview:
- Game-logic block that owns the player and exit tile positions consumed by the frame renderer.
- It is the initiator on the maze ROM's second read port: it issues tile lookups on `o_rom_en`/`o_rom_addr` and receives `i_rom_data`.
- On each movement tick it samples the direction buttons, range-checks the target tile and reads it from ROM. It commits the move only when the tile is free.
- It flags a win when the player reaches the exit.

Parameters:
- GRID_COLS, 40, tile columns (640/16).
- GRID_ROWS, 30, tile rows (480/16).
- FREE_RGB, 12'hFFF, `i_rom_data[11:0]` value marking a walkable tile; any other value is a wall.
- START_BCOL, 1, player reset column.
- START_BROW, 1, player reset row.
- EXIT_BCOL, 38, exit column.
- EXIT_BROW, 28, exit row.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_tick  in  1  one-cycle movement strobe (frame-rate derived)
- i_up  in  1  debounced button level
- i_down  in  1  debounced button level
- i_left  in  1  debounced button level
- i_right  in  1  debounced button level
- o_rom_en  out  1  ROM port-B read enable
- o_rom_addr  out  11  ROM port-B address, bcol*32 + brow
- i_rom_data  in  16  ROM port-B data, valid one cycle after en
- o_player_bcol  out  6  player tile column
- o_player_brow  out  6  player tile row
- o_exit_bcol  out  6  exit tile column (constant EXIT_BCOL)
- o_exit_brow  out  6  exit tile row (constant EXIT_BROW)
- o_moves  out  16  committed-move count, saturates at 16'hFFFF
- o_win  out  1  high once the player is on the exit; sticky

Behaviour:
- One clock domain.
- Reset is asynchronous and active-high, and all state is reset by `rst`.
- Reset values:
  - state = IDLE
  - player = (START_BCOL, START_BROW)
  - o_moves = 0
  - o_win = 0
  - o_rom_en = 0
  - o_rom_addr = 0
- FSM states: IDLE, REQ, CHECK, WIN.
- IDLE:
  - On `i_tick` with at least one button high, pick one direction by priority up > down > left > right.
  - Target = player ± 1 (up: brow-1, down: brow+1, left: bcol-1, right: bcol+1).
  - Out-of-grid target (underflow below 0, or ≥ GRID_COLS / ≥ GRID_ROWS): reject. Stay in IDLE, no ROM access, no count change.
  - Otherwise register target_bcol/target_brow and go to REQ.
  - `i_tick` with no button high: no action.
- REQ:
  - For exactly one cycle, `o_rom_en` = 1 and `o_rom_addr` = target_bcol*32 + target_brow, computed at 11 bits (zero-extend before multiply).
  - Go to CHECK.
- CHECK:
  - `i_rom_data` is valid in this state.
  - If `i_rom_data[11:0] == FREE_RGB`: player ← target and `o_moves` += 1 (saturating). If the target equals the exit, set `o_win` and go to WIN; otherwise go to IDLE.
  - If the tile is a wall: player unchanged, go to IDLE.
- WIN: terminal state. Buttons and ticks are ignored until reset. `o_rom_en` = 0.
- Latency: tick in cycle T → ROM enable in T+1 → new position visible at T+3. Each move takes 3 cycles minimum.
- `i_tick` arriving in REQ or CHECK is dropped, not queued.
- `o_rom_en` is 0 in every state except REQ. `o_rom_addr` holds its last value when `o_rom_en` is 0.
- All outputs are registered. The player position changes only at the CHECK→IDLE/WIN edge, so the renderer never sees a partial update.
- Reset during REQ or CHECK aborts the move: position returns to START and the pending ROM data is discarded.
- A player starting on the exit (START == EXIT) does not set `o_win` until a committed move ends on the exit.

Decomposition:
- Package `maze_pkg` holds:
  - state enum `maze_state_t` (IDLE, REQ, CHECK, WIN)
  - direction enum `dir_t` (NONE, UP, DOWN, LEFT, RIGHT)
  - constants TILE_SHIFT=4 and ROW_STRIDE=32
  - function `tile_addr(bcol, brow)` returning 11 bits
- Sub-module `maze_dir_sel`: combinational priority encoder from the four buttons to `dir_t`, plus target computation and in-bounds flag. Everything else (FSM, registers, counter) stays in `maze_ctrl`.

Test Plan:
- Free move: ROM model returns 16'h0FFF for all tiles; player at (1,1); `i_right` held, `i_tick` pulse → `o_rom_en` pulses once with `o_rom_addr`=2*32+1=65; 3 cycles after tick player=(2,1), `o_moves`=1.
- Wall block: ROM returns 16'h0000 at addr 1*32+2=34; `i_down` + `i_tick` from (1,1) → one ROM read at 34, player stays (1,1), `o_moves`=0.
- Boundary: player at (0,0) after a run of left/up moves; `i_left` + `i_tick` → no `o_rom_en` pulse, state IDLE, player (0,0).
- Priority and drop: `i_up` and `i_right` together + tick → address targets brow-1; a second tick in the cycle after (REQ) produces no extra ROM read.
- Win: walk a free path to (38,28) → `o_win`=1 on the final commit; further ticks with buttons give no ROM reads and no position change; `rst` pulse → player (1,1), `o_win`=0, `o_moves`=0.
- Reset mid-move: assert `rst` in the CHECK cycle → player (1,1), `o_rom_en`=0, state IDLE after release.
